conv_window_mult: RTL and testbench

Streaming 3x3 convolution front end that sits directly upstream of the 9-input adder tree. It accepts a raster-order pixel stream, builds the 3x3 sliding window with two line buffers, and multiplies each window element by a programmable kernel weight. It presents the nine products as one packed word, in the adder tree's input order, with a valid strobe. Only windows that lie fully inside the image (no padding) produce output.

---
 rtl/conv_window_mult.sv | 125 ++++++++++++
 tb/tb_conv_window_mult.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_mult.sv
// 3x3 sliding-window builder over a raster pixel stream; each window tap is
// multiplied by its kernel weight and presented in the adder tree's input order.
module conv_window_mult #(
    parameter int unsigned PIX_WIDTH = 8,
    parameter int unsigned KW_WIDTH  = 16,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned IMG_W     = 32,
    parameter int unsigned IMG_H     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_load,
    input  logic [3:0]            w_addr,
    input  logic [KW_WIDTH-1:0]   w_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PIX_WIDTH-1:0]  in_pixel,
    output logic [8:0][WIDTH-1:0] prod,
    output logic                  out_valid,
    output logic                  frame_done
);
    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam int unsigned PW = PIX_WIDTH + KW_WIDTH + 1;
    localparam int unsigned MW = (PW > WIDTH) ? PW : WIDTH;
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

    logic [8:0][KW_WIDTH-1:0]       weight;
    logic [CW-1:0]                  col;
    logic [RW-1:0]                  row;
    logic [PIX_WIDTH-1:0]           lb0 [IMG_W];
    logic [PIX_WIDTH-1:0]           lb1 [IMG_W];
    logic [2:0][2:0][PIX_WIDTH-1:0] win;
    logic                           emit_q;
    logic                           last_q;
    logic                           accept;
    logic [8:0][WIDTH-1:0]          prod_c;

    // Weight writes own the cycle; pixel intake waits.
    assign in_ready = rst & ~w_load;
    assign accept   = in_valid & in_ready;

    // Zero-extended pixel times signed weight, wrapped to WIDTH bits.
    function automatic logic [WIDTH-1:0] tap_mult(input logic [PIX_WIDTH-1:0] pix,
                                                  input logic [KW_WIDTH-1:0]  w);
        logic signed [MW-1:0] a;
        logic signed [MW-1:0] b;
        logic signed [MW-1:0] p;
        a = MW'($signed({1'b0, pix}));
        b = MW'($signed(w));
        p = a * b;
        return p[WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            weight <= '0;
        end else if (w_load && (w_addr <= 4'd8)) begin
            weight[w_addr] <= w_data;
        end
    end

    // Raster position of the pixel being accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == LAST_COL) begin
                col <= '0;
                row <= (row == LAST_ROW) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Line buffers hold the two previous rows; contents need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= in_pixel;
            lb0[col] <= lb1[col];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win    <= '0;
            emit_q <= 1'b0;
            last_q <= 1'b0;
        end else begin
            emit_q <= accept && (col >= CW'(2)) && (row >= RW'(2));
            last_q <= accept && (col == LAST_COL) && (row == LAST_ROW);
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= lb0[col];
                win[1][2] <= lb1[col];
                win[2][2] <= in_pixel;
            end
        end
    end

    for (genvar t = 0; t < 9; t++) begin : g_tap
        assign prod_c[t] = tap_mult(win[t / 3][t % 3], weight[t]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod       <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= emit_q;
            frame_done <= last_q;
            if (emit_q) begin
                prod <= prod_c;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_mult.sv
// Randomised scoreboard bench for conv_window_mult on a 4x4 image.
module tb_conv_window_mult;
    localparam int unsigned PW = 8;
    localparam int unsigned KW = 16;
    localparam int unsigned W  = 32;
    localparam int IW = 4;
    localparam int IH = 4;

    typedef struct {
        logic [8:0][W-1:0] p;
        logic              fd;
        int                cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              w_load = 1'b0;
    logic [3:0]        w_addr = '0;
    logic [KW-1:0]     w_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [PW-1:0]     in_pixel = '0;
    logic [8:0][W-1:0] prod;
    logic              out_valid;
    logic              frame_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_pulses = 0;
    int n_acc = 0;
    logic stall_mode = 1'b0;
    logic prev_v = 1'b0;
    logic cap_en = 1'b0;
    logic [8:0][W-1:0] cap;
    exp_t q[$];
    exp_t me;

    int img[int];
    int mw[int];
    int mrow = 0;
    int mcol = 0;

    conv_window_mult #(
        .PIX_WIDTH(PW), .KW_WIDTH(KW), .WIDTH(W), .IMG_W(IW), .IMG_H(IH)
    ) dut (
        .clk(clk), .rst(rst), .w_load(w_load), .w_addr(w_addr), .w_data(w_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .prod(prod), .out_valid(out_valid), .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 9; i++) mw[i] = 0;
        mrow = 0;
        mcol = 0;
        q.delete();
    endtask

    // Reference: window is the 3x3 image block ending at the accepted pixel.
    task automatic model_accept(input int pix, input int c0);
        exp_t   e;
        longint v;
        img[mrow * IW + mcol] = pix;
        n_acc++;
        if (mrow >= 2 && mcol >= 2) begin
            for (int i = 0; i < 9; i++) begin
                v = longint'(img[(mrow - 2 + i / 3) * IW + (mcol - 2 + i % 3)]) * longint'(mw[i]);
                e.p[4'(i)] = v[W-1:0];
            end
            e.fd  = (mrow == IH - 1) && (mcol == IW - 1);
            e.cyc = c0 + 2;
            q.push_back(e);
        end
        if (mcol == IW - 1) begin
            mcol = 0;
            mrow = (mrow == IH - 1) ? 0 : mrow + 1;
        end else begin
            mcol++;
        end
    endtask

    task automatic step(input logic v, input logic [7:0] pix, input logic wl,
                        input logic [3:0] wa, input logic [15:0] wd);
        int c0;
        in_valid = v;
        in_pixel = pix;
        w_load   = wl;
        w_addr   = wa;
        w_data   = wd;
        #1;
        chk1("in_ready", in_ready, rst & ~wl);
        @(posedge clk);
        c0 = cyc;
        if (rst) begin
            if (wl && wa <= 4'd8) mw[int'(wa)] = int'($signed(wd));
            else if (v && !wl) model_accept(int'(pix), c0);
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 4'd0, 16'h0000);
    endtask

    task automatic load_ramp();
        for (int k = 0; k < 9; k++) step(1'b0, 8'h00, 1'b1, 4'(k), 16'(k + 1));
    endtask

    task automatic frame_ramp(input logic stall);
        for (int p = 0; p < IW * IH; p++) begin
            step(1'b1, 8'(p), 1'b0, 4'd0, 16'h0000);
            if (stall) step(1'b0, 8'hEE, 1'b0, 4'd0, 16'h0000);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1({tag, "_out_valid"}, out_valid, 1'b0);
        chk1({tag, "_frame_done"}, frame_done, 1'b0);
        chk1({tag, "_in_ready"}, in_ready, 1'b0);
        for (int i = 0; i < 9; i++) chk32({tag, "_prod"}, prod[4'(i)], 32'h0);
    endtask

    // Monitor: every presented window is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid) begin
                n_pulses++;
                if (stall_mode) chk1("no_back_to_back", prev_v, 1'b0);
                if (cap_en) begin
                    cap    = prod;
                    cap_en = 1'b0;
                end
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got out_valid=1 want 0 at cycle %0d", cyc);
                end else begin
                    me = q.pop_front();
                    chk32("out_cycle", 32'(cyc), 32'(me.cyc));
                    for (int i = 0; i < 9; i++) chk32("prod", prod[4'(i)], me.p[4'(i)]);
                    chk1("frame_done", frame_done, me.fd);
                end
            end else begin
                chk1("frame_done_idle", frame_done, 1'b0);
            end
        end
        prev_v = out_valid;
    end

    initial begin
        int first_exp[9] = '{0, 2, 6, 16, 25, 36, 56, 72, 90};
        int target;
        int guard;
        model_clear();
        #1;
        check_reset_outputs("rst_init");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Weight port wins over a pending pixel for three cycles.
        for (int k = 0; k < 3; k++) step(1'b1, 8'hAA, 1'b1, 4'(k), 16'(k + 1));
        for (int k = 3; k < 9; k++) step(1'b0, 8'h00, 1'b1, 4'(k), 16'(k + 1));
        step(1'b0, 8'h00, 1'b1, 4'd12, 16'h7777);

        n_pulses = 0;
        cap_en   = 1'b1;
        frame_ramp(1'b0);
        idle(3);
        chk32("pulses_b2b", 32'(n_pulses), 32'd4);
        for (int i = 0; i < 9; i++) chk32("first_prod", cap[4'(i)], 32'(first_exp[4'(i)]));

        n_pulses   = 0;
        stall_mode = 1'b1;
        frame_ramp(1'b1);
        idle(3);
        stall_mode = 1'b0;
        chk32("pulses_stall", 32'(n_pulses), 32'd4);

        // Negative weight on the centre tap against a full-scale pixel.
        step(1'b0, 8'h00, 1'b1, 4'd4, 16'hFFFD);
        cap_en = 1'b1;
        for (int p = 0; p < IW * IH; p++) begin
            step(1'b1, (p == 5) ? 8'hFF : 8'($urandom_range(0, 255)), 1'b0, 4'd0, 16'h0000);
        end
        idle(3);
        chk32("signed_centre", cap[4], 32'hFFFFFD03);

        // Random pixels, gaps and weight writes over three frames.
        target = n_acc + 3 * IW * IH;
        guard  = 0;
        while (n_acc < target && guard < 2000) begin
            int r;
            r = $urandom_range(0, 9);
            guard++;
            if (r == 0)
                step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b1,
                     4'($urandom_range(0, 15)), 16'($urandom));
            else if (r < 3)
                step(1'b0, 8'($urandom_range(0, 255)), 1'b0, 4'd0, 16'h0000);
            else
                step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 4'd0, 16'h0000);
        end
        idle(3);

        // Asynchronous reset seven pixels into a frame.
        for (int p = 0; p < 7; p++) step(1'b1, 8'(p + 100), 1'b0, 4'd0, 16'h0000);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b1;
        load_ramp();
        n_pulses = 0;
        frame_ramp(1'b0);
        frame_ramp(1'b0);
        idle(3);
        chk32("pulses_after_rst", 32'(n_pulses), 32'd8);
        chk32("queue_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
